// File: rtl/coeff_interp_gen_pkg.sv
`default_nettype none
// =============================================================================
// Module : coeff_pkg
// Brief  : Interpolation tap tables (luma 8-tap, chroma 4-tap), shared types.
// Rev    : 1.0 - initial release
// =============================================================================
package coeff_pkg;

    localparam int NTAP  = 8;
    localparam int NCTAP = 4;

    typedef logic signed [7:0] coeff_t;

    // Indexed by alpha[2:1]; every row sums to 64.
    localparam coeff_t LUMA_TBL [4][NTAP] = '{
        '{ 8'sd0,  8'sd0,   8'sd0, 8'sd64,  8'sd0,   8'sd0, 8'sd0,  8'sd0},
        '{-8'sd1,  8'sd4, -8'sd10, 8'sd58, 8'sd17,  -8'sd5, 8'sd1,  8'sd0},
        '{-8'sd1,  8'sd4, -8'sd11, 8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1},
        '{ 8'sd0,  8'sd1,  -8'sd5, 8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1}
    };

    // Indexed by alpha[2:0]; placed on c2..c5.
    localparam coeff_t CHROMA_TBL [8][NCTAP] = '{
        '{ 8'sd0, 8'sd64,  8'sd0,  8'sd0},
        '{-8'sd2, 8'sd58, 8'sd10, -8'sd2},
        '{-8'sd4, 8'sd54, 8'sd16, -8'sd2},
        '{-8'sd6, 8'sd46, 8'sd28, -8'sd4},
        '{-8'sd4, 8'sd36, 8'sd36, -8'sd4},
        '{-8'sd4, 8'sd28, 8'sd46, -8'sd6},
        '{-8'sd2, 8'sd16, 8'sd54, -8'sd4},
        '{-8'sd2, 8'sd10, 8'sd58, -8'sd2}
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coeff_interp_gen_if.sv
`default_nettype none
// =============================================================================
// Module : read_interface / write_interface
// Brief  : Per-flux FIFO handshakes: show-ahead read side, full/write side.
// Rev    : 1.0 - initial release
// =============================================================================
interface read_interface #(
    parameter int FLUX = 2,
    parameter int DW   = 4
);
    logic [FLUX-1:0]         empty;
    logic [FLUX-1:0]         read;
    logic [FLUX-1:0][DW-1:0] dout;

    modport actor (input empty, input dout, output read);
    modport fifo  (output empty, output dout, input read);
endinterface

interface write_interface #(
    parameter int FLUX = 2,
    parameter int DW   = 10
);
    logic [FLUX-1:0] full;
    logic [FLUX-1:0] write;
    logic [DW-1:0]   din;

    modport actor (input full, output write, output din);
    modport fifo  (output full, input write, input din);
endinterface
`default_nettype wire

// File: rtl/coeff_interp_gen_rr.sv
`default_nettype none
// =============================================================================
// Module : rr_arbiter
// Brief  : Round-robin selector; search starts after the last granted index.
// Rev    : 1.0 - initial release
// =============================================================================
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic [N-1:0]  req,
    input  wire logic          advance,
    output logic      [N-1:0]  grant_onehot,
    output logic      [IW-1:0] grant_idx,
    output logic               any_grant
);

    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_cand;

    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any_grant    = 1'b0;
        w_cand       = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = IW'((int'(r_ptr) + k) % N);
            if (!any_grant && req[w_cand]) begin
                any_grant            = 1'b1;
                grant_idx            = w_cand;
                grant_onehot[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= IW'(N - 1);
        end else if (advance && any_grant) begin
            r_ptr <= grant_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/coeff_interp_gen.sv
`default_nettype none
// =============================================================================
// Module : coeff_interp_gen
// Brief  : Reads tagged alpha per flux, writes 8 interpolation taps one cycle
//          later. Macro COEFF_CHROMA_EN enables the chroma 4-tap table.
// Rev    : 1.0 - initial release
// =============================================================================
module coeff_interp_gen
    import coeff_pkg::*;
#(
    parameter int FLUX    = 2,
    parameter int COEFF_W = 9,
    parameter int ALPHA_W = 3
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     mode_chroma,
    read_interface.actor  read_port_alpha,
    write_interface.actor write_port_c0,
    write_interface.actor write_port_c1,
    write_interface.actor write_port_c2,
    write_interface.actor write_port_c3,
    write_interface.actor write_port_c4,
    write_interface.actor write_port_c5,
    write_interface.actor write_port_c6,
    write_interface.actor write_port_c7
);

    localparam int TAG_WIDTH = idx_width(FLUX);
    localparam int DIN_W     = TAG_WIDTH + COEFF_W;
    localparam int RD_W      = TAG_WIDTH + ALPHA_W;

    logic [FLUX-1:0]      w_full_any;
    logic [FLUX-1:0]      w_busy;
    logic [FLUX-1:0]      w_req;
    logic [FLUX-1:0]      w_grant_onehot;
    logic [TAG_WIDTH-1:0] w_grant_idx;
    logic                 w_any_grant;
    logic [RD_W-1:0]      w_sel;
    logic                 w_write;
    logic [FLUX-1:0]      w_wr_vec;
    coeff_t               w_tap [NTAP];
    logic [DIN_W-1:0]     w_din [NTAP];
    logic                 w_unused;

    logic                 r_valid;
    logic [TAG_WIDTH-1:0] r_flux;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [ALPHA_W-1:0]   r_alpha;
    logic                 r_chroma;

    assign w_full_any = write_port_c0.full | write_port_c1.full | write_port_c2.full
                      | write_port_c3.full | write_port_c4.full | write_port_c5.full
                      | write_port_c6.full | write_port_c7.full;

    // A flux whose token sits in the output register waits one cycle.
    assign w_busy = r_valid ? (FLUX'(1) << r_flux) : '0;
    assign w_req  = ~read_port_alpha.empty & ~w_full_any & ~w_busy & {FLUX{~rst}};

    rr_arbiter #(.N(FLUX)) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (w_req),
        .advance      (w_any_grant),
        .grant_onehot (w_grant_onehot),
        .grant_idx    (w_grant_idx),
        .any_grant    (w_any_grant)
    );

    assign read_port_alpha.read = w_grant_onehot;
    assign w_sel                = read_port_alpha.dout[w_grant_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_flux   <= '0;
            r_tag    <= '0;
            r_alpha  <= '0;
            r_chroma <= 1'b0;
        end else begin
            r_valid <= w_any_grant;
            if (w_any_grant) begin
                r_flux  <= w_grant_idx;
                r_tag   <= w_sel[RD_W-1:ALPHA_W];
                r_alpha <= w_sel[ALPHA_W-1:0];
`ifdef COEFF_CHROMA_EN
                r_chroma <= mode_chroma;
`else
                r_chroma <= 1'b0;
`endif
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            w_tap[k] = LUMA_TBL[r_alpha[2:1]][k];
        end
`ifdef COEFF_CHROMA_EN
        if (r_chroma) begin
            for (int k = 0; k < NTAP; k++) begin
                w_tap[k] = '0;
            end
            for (int j = 0; j < NCTAP; j++) begin
                w_tap[j + 2] = CHROMA_TBL[r_alpha[2:0]][j];
            end
        end
`endif
    end

    // Reset gates the outputs so a registered token is dropped, not written.
    assign w_write  = r_valid & ~rst;
    assign w_wr_vec = w_write ? (FLUX'(1) << r_flux) : '0;

    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            w_din[k] = w_write ? {r_tag, COEFF_W'(w_tap[k])} : '0;
        end
    end

    assign write_port_c0.write = w_wr_vec;
    assign write_port_c1.write = w_wr_vec;
    assign write_port_c2.write = w_wr_vec;
    assign write_port_c3.write = w_wr_vec;
    assign write_port_c4.write = w_wr_vec;
    assign write_port_c5.write = w_wr_vec;
    assign write_port_c6.write = w_wr_vec;
    assign write_port_c7.write = w_wr_vec;
    assign write_port_c0.din   = w_din[0];
    assign write_port_c1.din   = w_din[1];
    assign write_port_c2.din   = w_din[2];
    assign write_port_c3.din   = w_din[3];
    assign write_port_c4.din   = w_din[4];
    assign write_port_c5.din   = w_din[5];
    assign write_port_c6.din   = w_din[6];
    assign write_port_c7.din   = w_din[7];

    // Luma-only builds never look at mode_chroma or alpha[0].
    assign w_unused = ^{mode_chroma, r_alpha[0], r_chroma};

    a_no_full_while_held: assert property (@(posedge clk) disable iff (rst)
        (w_full_any & w_busy) == '0);

endmodule
`default_nettype wire

// File: tb/tb_coeff_interp_gen.sv
`default_nettype none
// =============================================================================
// Module : tb_coeff_interp_gen
// Brief  : Randomized scoreboard bench for coeff_interp_gen.
// Rev    : 1.0 - initial release
// =============================================================================
module tb_coeff_interp_gen;
    import coeff_pkg::*;

    localparam int FLUX    = 2;
    localparam int COEFF_W = 9;
    localparam int ALPHA_W = 3;
    localparam int TW      = 1;
    localparam int DW_R    = TW + ALPHA_W;
    localparam int DW_W    = TW + COEFF_W;
`ifdef COEFF_CHROMA_EN
    localparam int CHROMA_EN = 1;
`else
    localparam int CHROMA_EN = 0;
`endif

    localparam int LUMA_REF [4][8] = '{
        '{ 0, 0,   0, 64,  0,   0, 0,  0},
        '{-1, 4, -10, 58, 17,  -5, 1,  0},
        '{-1, 4, -11, 40, 40, -11, 4, -1},
        '{ 0, 1,  -5, 17, 58, -10, 4, -1}};
    localparam int CHR_REF [8][4] = '{
        '{ 0, 64,  0,  0}, '{-2, 58, 10, -2}, '{-4, 54, 16, -2}, '{-6, 46, 28, -4},
        '{-4, 36, 36, -4}, '{-4, 28, 46, -6}, '{-2, 16, 54, -4}, '{-2, 10, 58, -2}};

    typedef struct packed {
        int flux;
        int alpha;
        int chroma;
        int stamp;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mode_chroma;
    always #5 clk = ~clk;

    read_interface  #(.FLUX(FLUX), .DW(DW_R)) rd_if ();
    write_interface #(.FLUX(FLUX), .DW(DW_W)) wr_if [NTAP] ();

    logic [FLUX-1:0] full_drv [NTAP];
    logic [FLUX-1:0] wr_write [NTAP];
    logic [DW_W-1:0] wr_din   [NTAP];

    for (genvar g = 0; g < NTAP; g++) begin : g_wr
        assign wr_if[g].full = full_drv[g];
        assign wr_write[g]   = wr_if[g].write;
        assign wr_din[g]     = wr_if[g].din;
    end

    coeff_interp_gen #(.FLUX(FLUX), .COEFF_W(COEFF_W), .ALPHA_W(ALPHA_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .mode_chroma     (mode_chroma),
        .read_port_alpha (rd_if),
        .write_port_c0   (wr_if[0]),
        .write_port_c1   (wr_if[1]),
        .write_port_c2   (wr_if[2]),
        .write_port_c3   (wr_if[3]),
        .write_port_c4   (wr_if[4]),
        .write_port_c5   (wr_if[5]),
        .write_port_c6   (wr_if[6]),
        .write_port_c7   (wr_if[7])
    );

    int              checks = 0;
    int              errors = 0;
    int              cyc    = 0;
    int              src_q [FLUX][$];
    logic [FLUX-1:0] stall;
    logic [FLUX-1:0] rd_seen = '0;
    logic [FLUX-1:0] prev_rd = '0;
    exp_t            sb [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_tap(input int alpha, input int chroma, input int k);
        if (chroma != 0) return (k >= 2 && k <= 5) ? CHR_REF[alpha][k - 2] : 0;
        return LUMA_REF[alpha / 2][k];
    endfunction

    // Grant observer: legality of each read, and the expected token it implies.
    always @(negedge clk) begin : p_read_mon
        logic [FLUX-1:0] rv;
        logic            elig;
        exp_t            e;
        rv      = rd_if.read;
        rd_seen = rst ? '0 : rv;
        if (!rst && rv != '0) begin
            checks++;
            if (!$onehot(rv)) begin
                errors++;
                $display("FAIL read_onehot read=%b required one-hot", rv);
            end
            for (int i = 0; i < FLUX; i++) begin
                if (rv[i]) begin
                    elig = !rd_if.empty[i] && !prev_rd[i];
                    for (int k = 0; k < NTAP; k++) if (full_drv[k][i]) elig = 1'b0;
                    checks++;
                    if (!elig || src_q[i].size() == 0) begin
                        errors++;
                        $display("FAIL read_eligible flux=%0d empty=%b prev_read=%b required eligible",
                                 i, rd_if.empty, prev_rd);
                    end else begin
                        e.flux   = i;
                        e.alpha  = src_q[i][0];
                        e.chroma = (CHROMA_EN != 0) ? int'(mode_chroma) : 0;
                        e.stamp  = cyc;
                        sb.push_back(e);
                    end
                end
            end
        end
        prev_rd = rd_seen;
    end

    // Output observer: pops the scoreboard whenever the eight writes fire.
    always @(negedge clk) begin : p_write_mon
        logic [FLUX-1:0] wv;
        logic            wsame;
        logic            wany;
        logic [DW_W-1:0] dor;
        exp_t            e;
        int              f;
        int              sum;
        int              cv;
        wv = wr_write[0]; wsame = 1'b1; wany = 1'b0; dor = '0;
        for (int k = 0; k < NTAP; k++) begin
            if (wr_write[k] !== wv) wsame = 1'b0;
            wany = wany | (|wr_write[k]);
            dor  = dor | wr_din[k];
        end
        if (rst) begin
            sb.delete();
            checks++;
            if (wany || dor != '0 || rd_if.read != '0) begin
                errors++;
                $display("FAIL reset_outputs write=%0b din_or=%h read=%b required all 0",
                         wany, dor, rd_if.read);
            end
        end else if (wany) begin
            checks++;
            if (!wsame || !$onehot(wv)) begin
                errors++;
                $display("FAIL write_vector c0.write=%b same=%0b required identical one-hot", wv, wsame);
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write write=%b required no write", wv);
            end else begin
                e = sb.pop_front();
                if (e.stamp != cyc - 1) begin
                    errors++;
                    $display("FAIL write_latency read_cycle=%0d write_cycle=%0d required 1 apart", e.stamp, cyc);
                end
                f = 0;
                for (int i = 0; i < FLUX; i++) if (wv[i]) f = i;
                checks++;
                if (f != e.flux) begin
                    errors++;
                    $display("FAIL write_flux got=%0d required=%0d", f, e.flux);
                end
                sum = 0;
                for (int k = 0; k < NTAP; k++) begin
                    cv  = int'($signed(wr_din[k][COEFF_W-1:0]));
                    sum = sum + cv;
                    checks++;
                    if (cv != ref_tap(e.alpha, e.chroma, k) || int'(wr_din[k][DW_W-1 -: TW]) != e.flux) begin
                        errors++;
                        $display("FAIL tap_c%0d alpha=%0d chroma=%0d got coeff=%0d tag=%0d required coeff=%0d tag=%0d",
                                 k, e.alpha, e.chroma, cv, wr_din[k][DW_W-1 -: TW],
                                 ref_tap(e.alpha, e.chroma, k), e.flux);
                    end
                end
                checks++;
                if (sum != 64) begin
                    errors++;
                    $display("FAIL tap_sum got=%0d required=64", sum);
                end
            end
        end else begin
            checks++;
            if (dor != '0) begin
                errors++;
                $display("FAIL din_idle din_or=%h required 0", dor);
            end
            checks++;
            if (sb.size() > 0 && sb[0].stamp < cyc) begin
                errors++;
                $display("FAIL missing_write flux=%0d read_cycle=%0d required write at cycle %0d",
                         sb[0].flux, sb[0].stamp, sb[0].stamp + 1);
                void'(sb.pop_front());
            end
        end
    end

    task automatic refresh();
        for (int i = 0; i < FLUX; i++) begin
            rd_if.empty[i] = (src_q[i].size() == 0) || stall[i];
            rd_if.dout[i]  = (src_q[i].size() == 0) ? '0 : {TW'(i), ALPHA_W'(src_q[i][0])};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < FLUX; i++) begin
            if (rd_seen[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        refresh();
    endtask

    task automatic expect_read(input logic [FLUX-1:0] req, input string name);
        @(negedge clk);
        checks++;
        if (rd_if.read !== req) begin
            errors++;
            $display("FAIL %s read=%b required=%b", name, rd_if.read, req);
        end
    endtask

    initial begin : p_stim
        logic [FLUX-1:0] last;
        int              cnt0;
        int              cnt1;
        bit              found;
        rst = 1'b1; mode_chroma = 1'b0; stall = '0;
        for (int k = 0; k < NTAP; k++) full_drv[k] = '0;
        refresh();
        repeat (3) tick();
        rst = 1'b0;

        // First token after reset: flux 0, alpha 2 -> luma pos1 row.
        src_q[0].push_back(2);
        refresh();
        expect_read(2'b01, "first_grant");
        repeat (3) tick();

        // Both fluxes backlogged: grants must alternate.
        for (int n = 0; n < 10; n++) begin
            src_q[0].push_back(int'($urandom_range(0, 7)));
            src_q[1].push_back(int'($urandom_range(0, 7)));
        end
        refresh();
        last = '0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++;
            if (!$onehot(rd_if.read) || rd_if.read == last) begin
                errors++;
                $display("FAIL alternate step=%0d read=%b previous=%b required other flux", n, rd_if.read, last);
            end
            last = rd_if.read;
            tick();
        end
        repeat (25) tick();

        // Chroma request on flux 1 with alpha 3.
        mode_chroma = 1'b1;
        src_q[1].push_back(3);
        refresh();
        expect_read(2'b10, "chroma_grant");
        repeat (3) tick();
        mode_chroma = 1'b0;

        // One full flag on c5 blocks flux 0 only.
        full_drv[5][0] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            src_q[0].push_back(int'($urandom_range(0, 7)));
            src_q[1].push_back(int'($urandom_range(0, 7)));
        end
        refresh();
        cnt0 = 0; cnt1 = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            cnt0 += int'(rd_if.read[0]);
            cnt1 += int'(rd_if.read[1]);
            tick();
        end
        checks++;
        if (cnt0 != 0 || cnt1 == 0) begin
            errors++;
            $display("FAIL full_block reads0=%0d reads1=%0d required 0 and >0", cnt0, cnt1);
        end
        full_drv[5][0] = 1'b0;
        refresh();
        found = 1'b0;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            if (rd_if.read[0]) found = 1'b1;
            tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL full_release flux0 read=0 required read within 2 cycles");
        end
        repeat (30) tick();

        // Reset in the cycle after a grant drops the token.
        src_q[0].push_back(5);
        refresh();
        expect_read(2'b01, "pre_reset_grant");
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (wr_write[0] != '0 || wr_din[3] != '0) begin
            errors++;
            $display("FAIL reset_drop write=%b din=%h required 0", wr_write[0], wr_din[3]);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_write[0] != '0) begin
            errors++;
            $display("FAIL post_reset_write write=%b required 0", wr_write[0]);
        end
        repeat (5) tick();

        // Random traffic.
        for (int n = 0; n < 10000; n++) begin
            tick();
            for (int i = 0; i < FLUX; i++) begin
                if (src_q[i].size() < 4 && $urandom_range(0, 9) < 7)
                    src_q[i].push_back(int'($urandom_range(0, 7)));
                stall[i] = ($urandom_range(0, 4) == 0);
                for (int k = 0; k < NTAP; k++) full_drv[k][i] = 1'b0;
                if (!rd_seen[i] && $urandom_range(0, 3) == 0)
                    full_drv[$urandom_range(0, NTAP - 1)][i] = 1'b1;
            end
            if (rd_seen == '0 && $urandom_range(0, 19) == 0) mode_chroma = ~mode_chroma;
            refresh();
        end

        // Drain and confirm every expected token was written.
        stall = '0;
        for (int k = 0; k < NTAP; k++) full_drv[k] = '0;
        refresh();
        repeat (20) tick();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
